// File: rtl/axi_full_memory_model.sv
// AXI4-full slave memory: serves a mode-seeded preload pattern, stores write bursts and counts result beats.
// Optional: define AXI_MEM_BACKPRESSURE_EN for LFSR-driven READY gating and delayed VALID assertion.
module axi_full_memory_model #(
    parameter logic [1:0]            PAILLIER_MODE = 2'b10,
    parameter int                    TEST_TIMES    = 10,
    parameter int                    RESULT_BEATS  = 32,
    parameter int                    DATA_WIDTH    = 128,
    parameter int                    ADDR_WIDTH    = 64,
    parameter int                    ID_WIDTH      = 1,
    parameter int                    MEM_DEPTH     = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESET,
    input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [31:0]             wr_beat_count,
    output logic                    wr_done
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int LANES      = DATA_WIDTH / 32;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int MA         = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [31:0]           DONE_BEATS = 32'(TEST_TIMES * RESULT_BEATS);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [DATA_WIDTH-1:0] preload_word(input logic [15:0] idx);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int j = 0; j < LANES; j++) begin
            w[j*32 +: 32] = {PAILLIER_MODE, 6'b0, idx, 8'(j)};
        end
        return w;
    endfunction

    function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] idx, input logic [1:0] burst);
        if (idx >= DEPTH_A) return RESP_DECERR;
        if (burst == BURST_WRAP) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_idx(input logic [ADDR_WIDTH-1:0] idx, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? idx : idx + 1'b1;
    endfunction

    // Per-byte "written" flags let unwritten bytes fall back to the computed preload pattern.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [BYTES-1:0]      written [MEM_DEPTH] = '{default: '0};

    logic bp_ready;
    logic bp_valid;

`ifdef AXI_MEM_BACKPRESSURE_EN
    logic [15:0] lfsr_reg;
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
        end
    end
    assign bp_ready = lfsr_reg[0];
    assign bp_valid = lfsr_reg[1];
`else
    assign bp_ready = 1'b1;
    assign bp_valid = 1'b1;
`endif

    // Write channel
    w_state_t              w_state_reg;
    logic [ID_WIDTH-1:0]   w_id_reg;
    logic [ADDR_WIDTH-1:0] w_idx_reg;
    logic [1:0]            w_burst_reg;
    logic [1:0]            w_resp_acc_reg;
    logic [1:0]            bresp_reg;
    logic                  bvalid_reg;
    logic [31:0]           wr_beat_count_reg;
    logic                  w_fire;
    logic [1:0]            w_beat_resp;

    assign w_fire      = S_AXI_WVALID && S_AXI_WREADY;
    assign w_beat_resp = beat_resp(w_idx_reg, w_burst_reg);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state_reg       <= W_IDLE;
            w_id_reg          <= '0;
            w_idx_reg         <= '0;
            w_burst_reg       <= '0;
            w_resp_acc_reg    <= RESP_OKAY;
            bresp_reg         <= RESP_OKAY;
            bvalid_reg        <= 1'b0;
            wr_beat_count_reg <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        w_id_reg       <= S_AXI_AWID;
                        w_idx_reg      <= (S_AXI_AWADDR - BASE_ADDR) >> BYTE_SHIFT;
                        w_burst_reg    <= S_AXI_AWBURST;
                        w_resp_acc_reg <= RESP_OKAY;
                        w_state_reg    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        wr_beat_count_reg <= wr_beat_count_reg + 32'd1;
                        w_idx_reg         <= next_idx(w_idx_reg, w_burst_reg);
                        w_resp_acc_reg    <= worst_resp(w_resp_acc_reg, w_beat_resp);
                        if (S_AXI_WLAST) begin
                            bresp_reg   <= worst_resp(w_resp_acc_reg, w_beat_resp);
                            bvalid_reg  <= bp_valid;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (!bvalid_reg) begin
                        bvalid_reg <= 1'b1;
                    end else if (S_AXI_BREADY) begin
                        bvalid_reg  <= 1'b0;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // Memory array carries no reset so contents survive S_AXI_ARESET.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESET && w_fire && (w_idx_reg < DEPTH_A)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[w_idx_reg[MA-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                    written[w_idx_reg[MA-1:0]][b]    <= 1'b1;
                end
            end
        end
    end

    // Read channel
    r_state_t              r_state_reg;
    logic [ID_WIDTH-1:0]   r_id_reg;
    logic [ADDR_WIDTH-1:0] r_idx_reg;
    logic [7:0]            r_len_reg;
    logic [7:0]            r_beat_reg;
    logic [1:0]            r_burst_reg;
    logic                  rvalid_reg;
    logic                  rlast_reg;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state_reg <= R_IDLE;
            r_id_reg    <= '0;
            r_idx_reg   <= '0;
            r_len_reg   <= '0;
            r_beat_reg  <= '0;
            r_burst_reg <= '0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        r_id_reg    <= S_AXI_ARID;
                        r_idx_reg   <= (S_AXI_ARADDR - BASE_ADDR) >> BYTE_SHIFT;
                        r_len_reg   <= S_AXI_ARLEN;
                        r_burst_reg <= S_AXI_ARBURST;
                        r_beat_reg  <= '0;
                        rlast_reg   <= (S_AXI_ARLEN == 8'd0);
                        rvalid_reg  <= bp_valid;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (!rvalid_reg) begin
                        rvalid_reg <= 1'b1;
                    end else if (S_AXI_RREADY) begin
                        if (rlast_reg) begin
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            r_state_reg <= R_IDLE;
                        end else begin
                            r_beat_reg <= r_beat_reg + 8'd1;
                            r_idx_reg  <= next_idx(r_idx_reg, r_burst_reg);
                            rlast_reg  <= ((r_beat_reg + 8'd1) == r_len_reg);
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] rd_word;
    logic [BYTES-1:0]      rd_written;
    logic [DATA_WIDTH-1:0] rd_pre;
    logic [DATA_WIDTH-1:0] rd_merged;

    assign rd_word    = mem[r_idx_reg[MA-1:0]];
    assign rd_written = written[r_idx_reg[MA-1:0]];
    assign rd_pre     = preload_word(r_idx_reg[15:0]);

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_rd_merge
            assign rd_merged[gi*8 +: 8] = rd_written[gi] ? rd_word[gi*8 +: 8] : rd_pre[gi*8 +: 8];
        end
    endgenerate

    assign S_AXI_AWREADY = (w_state_reg == W_IDLE) && bp_ready;
    assign S_AXI_WREADY  = (w_state_reg == W_DATA) && bp_ready;
    assign S_AXI_BID     = w_id_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_ARREADY = (r_state_reg == R_IDLE) && bp_ready;
    assign S_AXI_RID     = r_id_reg;
    assign S_AXI_RDATA   = (r_idx_reg < DEPTH_A) ? rd_merged : '0;
    assign S_AXI_RRESP   = beat_resp(r_idx_reg, r_burst_reg);
    assign S_AXI_RLAST   = rlast_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign wr_beat_count = wr_beat_count_reg;
    assign wr_done       = (wr_beat_count_reg >= DONE_BEATS);

    // Beat sizes and AWLEN are intentionally not interpreted.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWLEN};
endmodule

// File: tb/tb_axi_full_memory_model.sv
// Directed self-checking bench for axi_full_memory_model in its default (zero-stall) build.
module tb_axi_full_memory_model;
    logic         clk = 1'b0;
    logic         srst;
    logic         aw_id, ar_id;
    logic [63:0]  aw_addr, ar_addr;
    logic [7:0]   aw_len, ar_len;
    logic [2:0]   aw_size, ar_size;
    logic [1:0]   aw_burst, ar_burst;
    logic         aw_valid, ar_valid;
    logic [127:0] w_data;
    logic [15:0]  w_strb;
    logic         w_last, w_valid, b_ready, r_ready;

    logic         S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BVALID;
    logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
    logic         S_AXI_ARREADY, S_AXI_RID, S_AXI_RLAST, S_AXI_RVALID;
    logic [127:0] S_AXI_RDATA;
    logic [31:0]  wr_beat_count;
    logic         wr_done;

    int checks = 0;
    int errors = 0;

    logic [127:0] rd_data [0:15];
    logic [1:0]   rd_resp [0:15];
    logic         rd_last [0:15];
    logic         rd_id   [0:15];
    int           rd_n;
    logic [1:0]   b_resp;
    logic         b_id;
    logic         done_trace [0:63];

    always #5 clk = ~clk;

    axi_full_memory_model dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(srst),
        .S_AXI_AWID(aw_id), .S_AXI_AWADDR(aw_addr), .S_AXI_AWLEN(aw_len), .S_AXI_AWSIZE(aw_size),
        .S_AXI_AWBURST(aw_burst), .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WLAST(w_last), .S_AXI_WVALID(w_valid),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(b_ready),
        .S_AXI_ARID(ar_id), .S_AXI_ARADDR(ar_addr), .S_AXI_ARLEN(ar_len), .S_AXI_ARSIZE(ar_size),
        .S_AXI_ARBURST(ar_burst), .S_AXI_ARVALID(ar_valid), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(r_ready),
        .wr_beat_count(wr_beat_count), .wr_done(wr_done)
    );

    // Preload pattern for PAILLIER_MODE=2'b10: lane j of word i = {2'b10, 6'b0, i[15:0], j[7:0]}.
    function automatic logic [127:0] pre_word(input int i);
        logic [127:0] w;
        for (int j = 0; j < 4; j++) w[j*32 +: 32] = {2'b10, 6'b0, 16'(i), 8'(j)};
        return w;
    endfunction

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic id);
        int t;
        rd_n = 0;
        ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_burst = burst; ar_id = id;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        ar_valid = 1'b0;
        r_ready = 1'b1;
        while (rd_n <= int'(len) && t < 200) begin
            if (S_AXI_RVALID) begin
                rd_data[rd_n] = S_AXI_RDATA; rd_resp[rd_n] = S_AXI_RRESP;
                rd_last[rd_n] = S_AXI_RLAST; rd_id[rd_n] = S_AXI_RID;
                rd_n++;
            end
            @(posedge clk); #1; t++;
        end
        r_ready = 1'b0;
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL read_timeout addr=%h got %0d beats want %0d", addr, rd_n, int'(len) + 1);
        end
        $display("read  addr=%h len=%0d burst=%0b beats=%0d", addr, len, burst, rd_n);
    endtask

    task automatic do_write(input logic [63:0] addr, input int nbeats, input logic [127:0] d0,
                            input logic [127:0] d1, input logic [15:0] strb, input logic [1:0] burst,
                            input logic id);
        int t;
        aw_valid = 1'b1; aw_addr = addr; aw_len = 8'(nbeats - 1); aw_burst = burst; aw_id = id;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            w_valid = 1'b1; w_data = (b == 0) ? d0 : d1; w_strb = strb; w_last = (b == nbeats - 1);
            while (!S_AXI_WREADY && t < 100) begin @(posedge clk); #1; t++; end
            @(posedge clk); #1;
            done_trace[b] = wr_done;
        end
        w_valid = 1'b0; w_last = 1'b0;
        b_ready = 1'b1;
        while (!S_AXI_BVALID && t < 150) begin @(posedge clk); #1; t++; end
        b_resp = S_AXI_BRESP; b_id = S_AXI_BID;
        @(posedge clk); #1;
        b_ready = 1'b0;
        checks++;
        if (t >= 150) begin
            errors++;
            $display("FAIL write_timeout addr=%h no BVALID", addr);
        end
        $display("write addr=%h beats=%0d bresp=%0b", addr, nbeats, b_resp);
    endtask

    task automatic test_reset;
        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (S_AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL reset_awready got %b want 1", S_AXI_AWREADY); end
        checks++; if (S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL reset_arready got %b want 1", S_AXI_ARREADY); end
        checks++; if (S_AXI_WREADY !== 1'b0) begin errors++; $display("FAIL reset_wready got %b want 0", S_AXI_WREADY); end
        checks++; if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b want 0", S_AXI_BVALID); end
        checks++; if (S_AXI_RVALID !== 1'b0 || S_AXI_RLAST !== 1'b0) begin errors++; $display("FAIL reset_rvalid_rlast got %b%b want 00", S_AXI_RVALID, S_AXI_RLAST); end
        checks++; if (wr_beat_count !== 32'd0 || wr_done !== 1'b0) begin errors++; $display("FAIL reset_count got %0d/%b want 0/0", wr_beat_count, wr_done); end
        srst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_incr;
        do_read(64'h0, 8'd3, 2'b01, 1'b1);
        checks++; if (rd_n != 4) begin errors++; $display("FAIL incr_beats got %0d want 4", rd_n); end
        for (int k = 0; k < 4 && k < rd_n; k++) begin
            checks++; if (rd_data[k] !== pre_word(k)) begin errors++; $display("FAIL incr_data beat %0d got %h want %h", k, rd_data[k], pre_word(k)); end
            checks++; if (rd_last[k] !== (k == 3)) begin errors++; $display("FAIL incr_rlast beat %0d got %b want %b", k, rd_last[k], k == 3); end
            checks++; if (rd_resp[k] !== 2'b00) begin errors++; $display("FAIL incr_rresp beat %0d got %b want 00", k, rd_resp[k]); end
        end
        checks++; if (rd_id[0] !== 1'b1) begin errors++; $display("FAIL incr_rid got %b want 1", rd_id[0]); end
    endtask

    task automatic test_write_read;
        do_write(64'h100, 2, {4{32'hAAAAAAAA}}, {4{32'h55555555}}, 16'hFFFF, 2'b01, 1'b1);
        checks++; if (b_resp !== 2'b00) begin errors++; $display("FAIL wr_bresp got %b want 00", b_resp); end
        checks++; if (b_id !== 1'b1) begin errors++; $display("FAIL wr_bid got %b want 1", b_id); end
        checks++; if (wr_beat_count !== 32'd2) begin errors++; $display("FAIL wr_count got %0d want 2", wr_beat_count); end
        do_read(64'h100, 8'd1, 2'b01, 1'b0);
        checks++; if (rd_data[0] !== {4{32'hAAAAAAAA}}) begin errors++; $display("FAIL wr_readback16 got %h want aaaa..", rd_data[0]); end
        checks++; if (rd_data[1] !== {4{32'h55555555}}) begin errors++; $display("FAIL wr_readback17 got %h want 5555..", rd_data[1]); end
    endtask

    task automatic test_partial_strobe;
        do_write(64'h50, 1, {4{32'hFFFFFFFF}}, '0, 16'h000F, 2'b01, 1'b0);
        do_read(64'h50, 8'd0, 2'b01, 1'b0);
        checks++;
        if (rd_data[0] !== {32'h80000503, 32'h80000502, 32'h80000501, 32'hFFFFFFFF}) begin
            errors++; $display("FAIL partial_strobe got %h want 800005038000050280000501ffffffff", rd_data[0]);
        end
    endtask

    task automatic test_out_of_range;
        do_read(64'h4000, 8'd0, 2'b01, 1'b0);
        checks++; if (rd_data[0] !== 128'd0) begin errors++; $display("FAIL oor_rdata got %h want 0", rd_data[0]); end
        checks++; if (rd_resp[0] !== 2'b11) begin errors++; $display("FAIL oor_rresp got %b want 11", rd_resp[0]); end
        do_write(64'h4000, 1, {4{32'h12345678}}, '0, 16'hFFFF, 2'b01, 1'b0);
        checks++; if (b_resp !== 2'b11) begin errors++; $display("FAIL oor_bresp got %b want 11", b_resp); end
        do_read(64'h0, 8'd0, 2'b01, 1'b0);
        checks++; if (rd_data[0] !== pre_word(0)) begin errors++; $display("FAIL oor_word0_kept got %h want %h", rd_data[0], pre_word(0)); end
    endtask

    task automatic test_fixed_wrap;
        do_read(64'h30, 8'd2, 2'b00, 1'b0);
        for (int k = 0; k < 3 && k < rd_n; k++) begin
            checks++; if (rd_data[k] !== pre_word(3)) begin errors++; $display("FAIL fixed_data beat %0d got %h want %h", k, rd_data[k], pre_word(3)); end
        end
        checks++; if (rd_last[2] !== 1'b1 || rd_resp[2] !== 2'b00) begin errors++; $display("FAIL fixed_last_resp got %b/%b want 1/00", rd_last[2], rd_resp[2]); end
        do_read(64'h20, 8'd1, 2'b10, 1'b0);
        checks++; if (rd_data[1] !== pre_word(3)) begin errors++; $display("FAIL wrap_incr got %h want %h", rd_data[1], pre_word(3)); end
        checks++; if (rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10) begin errors++; $display("FAIL wrap_rresp got %b %b want 10 10", rd_resp[0], rd_resp[1]); end
        do_write(64'h60, 2, {4{32'h01010101}}, {4{32'h02020202}}, 16'hFFFF, 2'b10, 1'b0);
        checks++; if (b_resp !== 2'b10) begin errors++; $display("FAIL wrap_bresp got %b want 10", b_resp); end
    endtask

    task automatic test_completion;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        checks++; if (wr_beat_count !== 32'd0 || wr_done !== 1'b0) begin errors++; $display("FAIL done_reset got %0d/%b want 0/0", wr_beat_count, wr_done); end
        for (int b = 0; b < 10; b++) begin
            do_write(64'h1000 + 64'(b) * 64'h200, 32, {4{32'hC0DE0000}}, {4{32'hBEEF0000}}, 16'hFFFF, 2'b01, 1'b0);
            if (b == 8) begin
                checks++; if (wr_beat_count !== 32'd288 || wr_done !== 1'b0) begin errors++; $display("FAIL done_after9 got %0d/%b want 288/0", wr_beat_count, wr_done); end
            end
        end
        checks++; if (done_trace[30] !== 1'b0) begin errors++; $display("FAIL done_early at beat 319 got %b want 0", done_trace[30]); end
        checks++; if (done_trace[31] !== 1'b1) begin errors++; $display("FAIL done_at320 got %b want 1", done_trace[31]); end
        checks++; if (wr_beat_count !== 32'd320) begin errors++; $display("FAIL done_count got %0d want 320", wr_beat_count); end
    endtask

    task automatic test_reset_mid_read;
        ar_valid = 1'b1; ar_addr = 64'h0; ar_len = 8'd7; ar_burst = 2'b01; ar_id = 1'b0;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        r_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== pre_word(2)) begin errors++; $display("FAIL midread_beat2 got %b/%h want 1/%h", S_AXI_RVALID, S_AXI_RDATA, pre_word(2)); end
        r_ready = 1'b0;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        checks++; if (S_AXI_RVALID !== 1'b0 || S_AXI_RLAST !== 1'b0) begin errors++; $display("FAIL midread_rvalid got %b/%b want 0/0", S_AXI_RVALID, S_AXI_RLAST); end
        checks++; if (S_AXI_ARREADY !== 1'b1 || S_AXI_WREADY !== 1'b0) begin errors++; $display("FAIL midread_ready got ar=%b w=%b want 1/0", S_AXI_ARREADY, S_AXI_WREADY); end
        do_read(64'h40, 8'd0, 2'b01, 1'b0);
        checks++; if (rd_data[0] !== pre_word(4) || rd_last[0] !== 1'b1) begin errors++; $display("FAIL midread_newar got %h/%b want %h/1", rd_data[0], rd_last[0], pre_word(4)); end
    endtask

    initial begin
        srst = 1'b1;
        aw_id = 1'b0; aw_addr = '0; aw_len = '0; aw_size = 3'd4; aw_burst = 2'b01; aw_valid = 1'b0;
        ar_id = 1'b0; ar_addr = '0; ar_len = '0; ar_size = 3'd4; ar_burst = 2'b01; ar_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        test_reset;
        test_read_incr;
        test_write_read;
        test_partial_strobe;
        test_out_of_range;
        test_fixed_wrap;
        test_completion;
        test_reset_mid_read;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
